// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the memory arbiter slice: the machine word, the RAM status
//   encoding, the arbiter state encoding and the error fill pattern returned on
//   a failed or timed-out RAM access.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM status as reported on ramstate.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IREQ  = 3'd1,
        DREQ  = 3'd2,
        IRESP = 3'd3,
        DRESP = 3'd4
    } arb_state_t;

    // Load value handed back when the RAM errors or never answers.
    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/access_timer.sv
// -----------------------------------------------------------------------------
// access_timer
//   8-bit cycle counter used to bound how long one RAM access may stall.
//   Ports:
//     CLK, nRST   clock (rising edge) and asynchronous active-low reset
//     i_clear     synchronous clear to zero (wins over i_enable)
//     i_enable    increment by one this cycle
//     o_expired   count has reached TIMEOUT
// -----------------------------------------------------------------------------
module access_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [7:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the clock edge, independent of ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == 8'(TIMEOUT));

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Serialises instruction-fetch and data requests onto one single-ported RAM.
//   Data wins ties unless the previous transaction was also data, so fetch can
//   never starve. Each access is latched for its whole RAM cycle, completes
//   with a one-cycle hit pulse, and is bounded by a timeout that turns a hung
//   RAM into an error response (load = BAD_WORD, sticky err).
//   Ports:
//     CLK, nRST                       clock / async active-low reset
//     imemREN, imemaddr               instruction read request
//     imemload, ihit                  instruction data and completion pulse
//     dmemREN, dmemWEN, dmemaddr,
//     dmemstore                       data read/write request
//     dmemload, dhit                  data read value and completion pulse
//     ramREN, ramWEN, ramaddr,
//     ramstore                        RAM command (address word aligned)
//     ramload, ramstate               RAM read data and status
//     err                             sticky error flag
// -----------------------------------------------------------------------------
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] imemload,
    output logic              ihit,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dmemload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_store;
    logic              r_is_write;
    logic [WORD_W-1:0] r_imemload;
    logic [WORD_W-1:0] r_dmemload;
    logic              r_err;
    logic              r_last_was_data;

    ramstate_t         w_ramstate;
    logic              w_data_pend;
    logic              w_expired;
    logic              w_req_done;
    logic              w_req_bad;
    logic              w_timer_en;
    logic              w_timer_clr;

    assign w_ramstate  = ramstate_t'(ramstate);
    assign w_data_pend = dmemREN | dmemWEN;

    // A good ACCESS wins over a timeout that expires in the same cycle.
    assign w_req_done = (w_ramstate == ACCESS) || (w_ramstate == ERROR) || w_expired;
    assign w_req_bad  = (w_ramstate != ACCESS) && ((w_ramstate == ERROR) || w_expired);

    // The count steps on the edge into a request state and on each stalled
    // cycle, so it equals the number of request cycles seen so far.
    assign w_timer_en  = (w_next_state == IREQ) || (w_next_state == DREQ);
    assign w_timer_clr = (r_state == IRESP) || (r_state == DRESP);

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_clear   (w_timer_clr),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: every signal assigned in a combinational block gets a default at the
    // top; otherwise an unassigned path would infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_data_pend && (!imemREN || !r_last_was_data)) begin
                    w_next_state = DREQ;
                end else if (imemREN) begin
                    w_next_state = IREQ;
                end
            end
            IREQ:    if (w_req_done) w_next_state = IRESP;
            DREQ:    if (w_req_done) w_next_state = DRESP;
            IRESP:   w_next_state = IDLE;
            DRESP:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request latches, load registers and flags.
    // NOTE: the latched request registers are reset as well, so ramaddr and
    // ramstore cannot carry stale values from before a reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr          <= '0;
            r_store         <= '0;
            r_is_write      <= 1'b0;
            r_imemload      <= '0;
            r_dmemload      <= '0;
            r_err           <= 1'b0;
            r_last_was_data <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_next_state == DREQ) begin
                        r_addr     <= dmemaddr;
                        r_store    <= dmemstore;
                        // A simultaneous read+write is serviced as a write.
                        r_is_write <= dmemWEN;
                        if (dmemREN && dmemWEN) r_err <= 1'b1;
                    end else if (w_next_state == IREQ) begin
                        r_addr <= imemaddr;
                    end
                end
                IREQ: begin
                    if (w_ramstate == ACCESS) begin
                        r_imemload <= ramload;
                    end else if (w_req_bad) begin
                        r_imemload <= WORD_W'(BAD_WORD);
                        r_err      <= 1'b1;
                    end
                end
                DREQ: begin
                    if (w_ramstate == ACCESS) begin
                        r_dmemload <= ramload;
                    end else if (w_req_bad) begin
                        r_dmemload <= WORD_W'(BAD_WORD);
                        r_err      <= 1'b1;
                    end
                end
                IRESP:   r_last_was_data <= 1'b0;
                DRESP:   r_last_was_data <= 1'b1;
                default: ;
            endcase
        end
    end

    // Output decode: strobes and hits are pure functions of the state, so an
    // asynchronous reset clears them immediately.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        unique case (r_state)
            IREQ: begin
                ramREN   = 1'b1;
                ramaddr  = r_addr & ~WORD_W'(3);
                ramstore = r_store;
            end
            DREQ: begin
                ramREN   = !r_is_write;
                ramWEN   = r_is_write;
                ramaddr  = r_addr & ~WORD_W'(3);
                ramstore = r_store;
            end
            IRESP:   ihit = 1'b1;
            DRESP:   dhit = 1'b1;
            default: ;
        endcase
    end

    assign imemload = r_imemload;
    assign dmemload = r_dmemload;
    assign err      = r_err;

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly downstream of the request unit and caches. Arbitrates instruction and data requests onto the single-ported RAM interface.
- Serialises the two request streams through a registered FSM. Latches each request for the duration of its RAM access.
- Returns a one-cycle hit pulse with registered load data to the requester.
- Data has priority, with a fairness toggle so instruction fetch cannot starve. A per-access timeout converts a hung RAM into an error response.

Parameters:
- WORD_W, 32, width of address and data words.
- TIMEOUT, 15, maximum cycles in a request state without ACCESS before the access is aborted (range 1..255).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  instruction read request.
- imemaddr  in  WORD_W  instruction address.
- imemload  out  WORD_W  instruction read data, valid while ihit=1.
- ihit  out  1  one-cycle instruction completion pulse.
- dmemREN  in  1  data read request.
- dmemWEN  in  1  data write request.
- dmemaddr  in  WORD_W  data address.
- dmemstore  in  WORD_W  data write value.
- dmemload  out  WORD_W  data read data, valid while dhit=1.
- dhit  out  1  one-cycle data completion pulse.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address, bits [1:0] forced to 0.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky error flag.

Behaviour:
Clocking and reset:
- Single clock CLK, rising edge; nRST is asynchronous and active-low.
- Reset forces state=IDLE, last_was_data=0, timer=0 and err=0.
- Reset forces every output to 0: all strobes, hits, ramaddr, ramstore, imemload and dmemload.
- An access in flight when reset asserts is discarded with no hit.

FSM states: IDLE, IREQ, DREQ, IRESP, DRESP.

IDLE:
- Drives no RAM strobes.
- Data pending (dmemREN|dmemWEN) and (!imemREN or !last_was_data): go to DREQ.
- Otherwise, if imemREN: go to IREQ.
- On entry to DREQ, latch dmemaddr, dmemstore and is_write=dmemWEN. dmemWEN=dmemREN=1 is serviced as a write and sets err.
- On entry to IREQ, latch imemaddr.

DREQ / IREQ:
- Drive ramaddr from the latched address, ramstore from the latched data.
- DREQ drives ramWEN=is_write and ramREN=!is_write; IREQ drives ramREN=1.
- The timer increments each cycle spent in the state.
- ramstate=ACCESS: register ramload into the matching load register, then go to DRESP/IRESP.
- ramstate=ERROR, or timer reaches TIMEOUT: load register <= 32'hBAD1BAD1, set err, go to DRESP/IRESP.
- FREE or BUSY: stay.
- Requester inputs are ignored while in a request state; latched values hold.

DRESP / IRESP:
- dhit (ihit) = 1 for exactly this cycle; RAM strobes are 0.
- Set last_was_data=1 (DRESP) or 0 (IRESP), clear the timer, return to IDLE.

Timing and throughput:
- Minimum latency from request visible in IDLE to hit is 3 cycles: IDLE, REQ with ACCESS, RESP.
- At most one transaction is outstanding; ihit and dhit are never high together.
- If the requester still holds its request in the cycle after the hit, it is treated as a new request. A repeated read is harmless; a repeated write rewrites the same value.

Flags and data outputs:
- err is sticky until reset.
- imemload and dmemload hold their last value between hits.

Decomposition:
- cpu_types_pkg holds: word_t; ramstate_t (FREE, BUSY, ACCESS, ERROR); arb_state_t (IDLE, IREQ, DREQ, IRESP, DRESP); constant BAD_WORD = 32'hBAD1BAD1.
- One sub-module, access_timer: an 8-bit counter with clear and enable inputs and an expired output at count==TIMEOUT.
- The FSM, latches and output muxing stay in memory_arbiter.

Test Plan:
- Reset mid-DREQ with ramstate=BUSY, assert nRST=0: all outputs 0 immediately (asynchronous), no dhit afterwards, FSM restarts in IDLE.
- imemREN=1 at 0x40, ramstate=ACCESS on the first request cycle, ramload=0x8C220004: ramREN=1 and ramaddr=0x40 in IREQ; ihit=1 with imemload=0x8C220004 on cycle 3; dhit stays 0.
- dmemWEN=1, addr=0x103 (low bits set), store=0xDEADBEEF, ramstate BUSY for 4 cycles then ACCESS: ramaddr=0x100 and ramWEN=1 held for 5 cycles; dhit on the following cycle; err=0.
- imemREN and dmemREN held together for 4 transactions: service order is D, I, D, I; hits alternate dhit, ihit.
- ramstate held BUSY with TIMEOUT=15: abort after 15 request cycles; hit with load=0xBAD1BAD1; err=1 and stays 1 through later good accesses.
- dmemREN=dmemWEN=1: a write is issued (ramWEN=1, ramREN=0) and err=1. Separately, ramstate=ERROR on a read: dhit with 0xBAD1BAD1.
